espic_node_if: RTL and testbench

- Node-side endpoint of the ESPIC interrupt/command interface; one instance per processing node.
- Receives the controller's IRQ lines (timer IRQ0, mutex IRQ1 pair, memory IRQ2), synchronises and edge-detects them, and latches them as pending.
- Presents one prioritised, maskable request with a vector/ack/EOI handshake to the node CPU.
- In the other direction, encodes CPU commands into the 16-bit op word the controller decodes (IRQ1 priority set, IRQ2 raise) and holds each word on the bus for a fixed number of cycles.

---
 rtl/espic_node_if.sv | 150 +++++++++++++++
 tb/tb_espic_node_if.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/espic_node_if.sv
// Node-side ESPIC endpoint: synchronises and latches controller IRQs into one
// prioritised CPU request with ack/EOI, and encodes CPU commands into held op words.
module espic_node_if #(
  parameter int NODE_ID        = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int OP_HOLD_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        irq0_in,
  input  logic [1:0]  irq1_in,
  input  logic        irq2_in,
  input  logic [2:0]  irq_mask,
  output logic        irq_req,
  output logic [1:0]  irq_vec,
  input  logic        irq_ack,
  input  logic        irq_eoi,
  output logic [2:0]  pending,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_type,
  input  logic [3:0]  cmd_prio,
  output logic        cmd_ready,
  output logic [15:0] out_op,
  output logic [1:0]  dbg_state
);

  // Handshakes: a command transfers on a rising CLK edge where cmd_valid & cmd_ready;
  // irq_ack counts only while irq_req is high, irq_eoi only while in service.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  localparam logic            NODE_SEL  = NODE_ID[0];
  localparam int              CW        = (OP_HOLD_CYCLES > 1) ? $clog2(OP_HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   HOLD_LAST = CW'(OP_HOLD_CYCLES - 1);

  logic [2:0]    r_sync [SYNC_STAGES];
  logic [2:0]    r_hist;
  logic [2:0]    r_pend;
  logic [1:0]    r_state;
  logic          r_req;
  logic [1:0]    r_vec;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_op;

  logic [2:0]    w_in;
  logic [2:0]    w_rise;
  logic [2:0]    w_elig;
  logic [2:0]    w_vec_hot;
  logic [2:0]    w_clr;
  logic          w_found;
  logic [1:0]    w_win;
  logic [15:0]   w_op;

  assign w_in      = {irq2_in, irq1_in[NODE_SEL], irq0_in};
  assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_elig    = r_pend & ~irq_mask;
  assign w_vec_hot = 3'b001 << r_vec;
  assign w_clr     = ((r_state == ST_REQ) && irq_ack) ? w_vec_hot : 3'b000;

  always_comb begin
    w_found = 1'b1;
    w_win   = 2'd0;
    if (w_elig[0])      w_win = 2'd0;
    else if (w_elig[1]) w_win = 2'd1;
    else if (w_elig[2]) w_win = 2'd2;
    else                w_found = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 3'b000;
      r_hist <= 3'b000;
      r_pend <= 3'b000;
    end else begin
      r_sync[0] <= w_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= r_sync[SYNC_STAGES-1];
      // A rise landing on the same edge as its ack must survive, so OR it in last.
      r_pend <= (r_pend & ~w_clr) | w_rise;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_vec   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_found) begin
          r_state <= ST_REQ;
          r_req   <= 1'b1;
          r_vec   <= w_win;
        end
        ST_REQ: if (irq_ack) begin
          r_state <= ST_SVC;
          r_req   <= 1'b0;
        end else if (|(irq_mask & w_vec_hot)) begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
        ST_SVC: if (irq_eoi) r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (cmd_type)
      2'd0:    w_op = {12'h2F1, cmd_prio};
      2'd1:    w_op = 16'h3F11;
      2'd2:    w_op = 16'h3F12;
      default: w_op = 16'h0000;
    endcase
  end

  // r_cnt counts the remaining hold cycles after the current one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_op   <= 16'h0000;
    end else if (!r_busy) begin
      if (cmd_valid) begin
        r_busy <= 1'b1;
        r_op   <= w_op;
        r_cnt  <= HOLD_LAST;
      end
    end else if (r_cnt == '0) begin
      r_busy <= 1'b0;
      r_op   <= 16'h0000;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign irq_req   = r_req;
  assign irq_vec   = r_vec;
  assign pending   = r_pend;
  assign cmd_ready = ~r_busy;
  assign out_op    = r_op;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_espic_node_if.sv
// Bench for espic_node_if: directed scenarios plus a randomized run against a
// cycle-level reference model of pending/request/encoder behaviour.
module tb_espic_node_if;

  localparam int SS   = 2;
  localparam int HOLD = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        irq0_in = 1'b0, irq2_in = 1'b0;
  logic [1:0]  irq1_in = 2'b00;
  logic [2:0]  irq_mask = 3'b000;
  logic        irq_ack = 1'b0, irq_eoi = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = 2'd0;
  logic [3:0]  cmd_prio = 4'd0;
  logic        irq_req, cmd_ready;
  logic [1:0]  irq_vec, dbg_state;
  logic [2:0]  pending;
  logic [15:0] out_op;
  logic        n1_req, n1_ready;
  logic [1:0]  n1_vec, n1_state;
  logic [2:0]  n1_pending;
  logic [15:0] n1_op;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  espic_node_if #(.NODE_ID(0), .SYNC_STAGES(SS), .OP_HOLD_CYCLES(HOLD)) u_dut (
    .CLK(CLK), .RST(RST), .irq0_in(irq0_in), .irq1_in(irq1_in), .irq2_in(irq2_in),
    .irq_mask(irq_mask), .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .irq_eoi(irq_eoi), .pending(pending), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_prio(cmd_prio), .cmd_ready(cmd_ready), .out_op(out_op), .dbg_state(dbg_state)
  );

  espic_node_if #(.NODE_ID(1), .SYNC_STAGES(SS), .OP_HOLD_CYCLES(HOLD)) u_dut1 (
    .CLK(CLK), .RST(RST), .irq0_in(irq0_in), .irq1_in(irq1_in), .irq2_in(irq2_in),
    .irq_mask(irq_mask), .irq_req(n1_req), .irq_vec(n1_vec), .irq_ack(irq_ack),
    .irq_eoi(irq_eoi), .pending(n1_pending), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_prio(cmd_prio), .cmd_ready(n1_ready), .out_op(n1_op), .dbg_state(n1_state)
  );

  // Reference model: 0 = idle, 1 = requesting, 2 = in service.
  int          m_state;
  logic [1:0]  m_vec;
  logic [2:0]  m_pend;
  logic [2:0]  m_smp [0:SS];
  logic [15:0] m_op;
  int          m_left;

  always @(posedge CLK or negedge RST) begin
    logic [2:0] rise, clr;
    logic       found;
    logic [1:0] win;
    if (!RST) begin
      m_state <= 0; m_vec <= 2'd0; m_pend <= 3'b000; m_op <= 16'h0000; m_left <= 0;
      for (int k = 0; k <= SS; k++) m_smp[k] <= 3'b000;
    end else begin
      rise  = m_smp[SS-1] & ~m_smp[SS];
      clr   = 3'b000;
      found = 1'b0;
      win   = 2'd0;
      for (int s = 2; s >= 0; s--)
        if (m_pend[s] && !irq_mask[s]) begin found = 1'b1; win = 2'(s); end
      if (m_state == 0 && found) begin
        m_state <= 1; m_vec <= win;
      end else if (m_state == 1 && irq_ack) begin
        clr[m_vec] = 1'b1; m_state <= 2;
      end else if (m_state == 1 && irq_mask[m_vec]) begin
        m_state <= 0;
      end else if (m_state == 2 && irq_eoi) begin
        m_state <= 0;
      end
      m_pend <= (m_pend & ~clr) | rise;
      m_smp[0] <= {irq2_in, irq1_in[0], irq0_in};
      for (int k = 1; k <= SS; k++) m_smp[k] <= m_smp[k-1];
      if (m_left == 0 && cmd_valid) begin
        m_left <= HOLD;
        case (cmd_type)
          2'd0: m_op <= {12'h2F1, cmd_prio};
          2'd1: m_op <= 16'h3F11;
          2'd2: m_op <= 16'h3F12;
          default: m_op <= 16'h0000;
        endcase
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_op <= 16'h0000;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic serve();
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    step(3);
    n_checks++;
    if ({irq_req, irq_vec, pending, cmd_ready, out_op, dbg_state} !== {1'b0, 2'd0, 3'b000, 1'b1, 16'h0000, 2'd0}) begin
      n_errors++;
      $display("FAIL reset_state: req=%b vec=%0d pend=%b ready=%b op=%h st=%0d, want 0 0 000 1 0000 0",
               irq_req, irq_vec, pending, cmd_ready, out_op, dbg_state);
    end
    RST = 1'b1;
    step(1);
    irq0_in = 1'b1; irq2_in = 1'b1;
    step(2);
    irq0_in = 1'b0; irq2_in = 1'b0;
    for (int k = 0; k < 10 && !irq_req; k++) step(1);
    irq_ack = 1'b1; cmd_valid = 1'b1; cmd_type = 2'd1;
    step(1);
    irq_ack = 1'b0; cmd_valid = 1'b0;
    n_checks++;
    if ({out_op, pending, dbg_state} !== {16'h3F11, 3'b100, 2'd2}) begin
      n_errors++;
      $display("FAIL reset_setup: op=%h pend=%b st=%0d, want 3f11 100 2", out_op, pending, dbg_state);
    end
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if ({out_op, irq_req, pending, cmd_ready, dbg_state} !== {16'h0000, 1'b0, 3'b000, 1'b1, 2'd0}) begin
      n_errors++;
      $display("FAIL reset_midop: op=%h req=%b pend=%b ready=%b st=%0d, want 0000 0 000 1 0",
               out_op, irq_req, pending, cmd_ready, dbg_state);
    end
    step(1);
    RST = 1'b1;
    step(1);
  endtask

  task automatic test_latency();
    irq2_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      if (i == 5) irq2_in = 1'b0;
      if (i == 2) begin
        n_checks++;
        if (pending !== 3'b000) begin
          n_errors++; $display("FAIL latency_early: pend=%b, want 000", pending);
        end
      end
      if (i == 3) begin
        n_checks++;
        if ({irq_req, pending} !== {1'b0, 3'b100}) begin
          n_errors++; $display("FAIL latency_pend: req=%b pend=%b, want 0 100", irq_req, pending);
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({irq_req, irq_vec} !== {1'b1, 2'd2}) begin
          n_errors++; $display("FAIL latency_req: req=%b vec=%0d, want 1 2", irq_req, irq_vec);
        end
      end
    end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    n_checks++;
    if ({irq_req, pending, dbg_state} !== {1'b0, 3'b000, 2'd2}) begin
      n_errors++; $display("FAIL ack_clear: req=%b pend=%b st=%0d, want 0 000 2", irq_req, pending, dbg_state);
    end
    irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
    n_checks++;
    if ({irq_req, dbg_state} !== {1'b0, 2'd0}) begin
      n_errors++; $display("FAIL eoi_idle: req=%b st=%0d, want 0 0", irq_req, dbg_state);
    end
  endtask

  task automatic test_priority_mask();
    irq0_in = 1'b1; irq1_in = 2'b01;
    step(2); irq0_in = 1'b0; irq1_in = 2'b00; step(2);
    n_checks++;
    if ({irq_req, irq_vec, pending} !== {1'b1, 2'd0, 3'b011}) begin
      n_errors++; $display("FAIL prio_first: req=%b vec=%0d pend=%b, want 1 0 011", irq_req, irq_vec, pending);
    end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
    step(1);
    n_checks++;
    if ({irq_req, irq_vec} !== {1'b1, 2'd1}) begin
      n_errors++; $display("FAIL prio_second: req=%b vec=%0d, want 1 1", irq_req, irq_vec);
    end
    serve();
    irq_mask = 3'b001;
    irq0_in = 1'b1; irq1_in = 2'b01;
    step(2); irq0_in = 1'b0; irq1_in = 2'b00; step(2);
    n_checks++;
    if ({irq_req, irq_vec} !== {1'b1, 2'd1}) begin
      n_errors++; $display("FAIL mask_vec: req=%b vec=%0d, want 1 1", irq_req, irq_vec);
    end
    serve(); step(2);
    n_checks++;
    if ({irq_req, pending} !== {1'b0, 3'b001}) begin
      n_errors++; $display("FAIL mask_retain: req=%b pend=%b, want 0 001", irq_req, pending);
    end
    irq_mask = 3'b000; step(1);
    irq_mask = 3'b001; step(1);
    n_checks++;
    if ({irq_req, pending, dbg_state} !== {1'b0, 3'b001, 2'd0}) begin
      n_errors++; $display("FAIL mask_drop: req=%b pend=%b st=%0d, want 0 001 0", irq_req, pending, dbg_state);
    end
    irq_mask = 3'b000; step(1);
    n_checks++;
    if ({irq_req, irq_vec} !== {1'b1, 2'd0}) begin
      n_errors++; $display("FAIL unmask_req: req=%b vec=%0d, want 1 0", irq_req, irq_vec);
    end
    serve();
  endtask

  task automatic test_rearm();
    irq1_in = 2'b01; step(2); irq1_in = 2'b00;
    for (int k = 0; k < 10 && !irq_req; k++) step(1);
    n_checks++;
    if ({irq_req, irq_vec} !== {1'b1, 2'd1}) begin
      n_errors++; $display("FAIL rearm_first: req=%b vec=%0d, want 1 1", irq_req, irq_vec);
    end
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
    irq1_in = 2'b01; step(2); irq1_in = 2'b00; step(3);
    n_checks++;
    if ({irq_req, pending} !== {1'b0, 3'b010}) begin
      n_errors++; $display("FAIL rearm_svc: req=%b pend=%b, want 0 010", irq_req, pending);
    end
    irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
    step(1);
    n_checks++;
    if ({irq_req, irq_vec} !== {1'b1, 2'd1}) begin
      n_errors++; $display("FAIL rearm_second: req=%b vec=%0d, want 1 1", irq_req, irq_vec);
    end
    serve();
  endtask

  task automatic test_level_hold();
    int reqs = 0;
    irq0_in = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      irq_ack = 1'b0; irq_eoi = 1'b0;
      if (irq_req) begin reqs++; irq_ack = 1'b1; end
      else if (dbg_state == 2'd2) irq_eoi = 1'b1;
    end
    irq0_in = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
    step(1); irq_eoi = 1'b1; step(1); irq_eoi = 1'b0; step(4);
    n_checks++;
    if ({reqs, pending, irq_req} !== {32'd1, 3'b000, 1'b0}) begin
      n_errors++; $display("FAIL level_once: reqs=%0d pend=%b req=%b, want 1 000 0", reqs, pending, irq_req);
    end
  endtask

  task automatic test_encoder();
    cmd_valid = 1'b1; cmd_type = 2'd0; cmd_prio = 4'h5;
    step(1);
    cmd_valid = 1'b0;
    for (int h = 0; h < HOLD; h++) begin
      n_checks++;
      if ({cmd_ready, out_op} !== {1'b0, 16'h2F15}) begin
        n_errors++; $display("FAIL enc_hold%0d: ready=%b op=%h, want 0 2f15", h, cmd_ready, out_op);
      end
      cmd_valid = (h == 1); cmd_type = 2'd2;
      step(1);
    end
    n_checks++;
    if ({cmd_ready, out_op} !== {1'b1, 16'h0000}) begin
      n_errors++; $display("FAIL enc_release: ready=%b op=%h, want 1 0000", cmd_ready, out_op);
    end
    cmd_valid = 1'b1; cmd_type = 2'd2; step(1); cmd_valid = 1'b0;
    step(HOLD - 1);
    n_checks++;
    if (out_op !== 16'h3F12) begin
      n_errors++; $display("FAIL enc_type2: op=%h, want 3f12", out_op);
    end
    step(1);
    cmd_valid = 1'b1; cmd_type = 2'd3; step(1); cmd_valid = 1'b0;
    n_checks++;
    if ({cmd_ready, out_op} !== {1'b0, 16'h0000}) begin
      n_errors++; $display("FAIL enc_type3: ready=%b op=%h, want 0 0000", cmd_ready, out_op);
    end
    step(HOLD);
  endtask

  task automatic test_back_to_back();
    logic [15:0] seen [0:5];
    logic [15:0] want [0:5];
    want = '{16'h3F11, 16'h3F11, 16'h3F11, 16'h3F11, 16'h0000, 16'h3F11};
    cmd_valid = 1'b1; cmd_type = 2'd1;
    for (int i = 0; i < 6; i++) begin step(1); seen[i] = out_op; end
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (seen[i] !== want[i]) begin
        n_errors++; $display("FAIL b2b_cycle%0d: op=%h, want %h", i, seen[i], want[i]);
      end
    end
    step(HOLD + 1);
  endtask

  task automatic test_node_id1();
    irq1_in = 2'b01; step(2); irq1_in = 2'b00; step(3);
    n_checks++;
    if ({n1_pending[1], pending[1]} !== 2'b01) begin
      n_errors++; $display("FAIL node1_ignore: n1_pend1=%b n0_pend1=%b, want 0 1", n1_pending[1], pending[1]);
    end
    step(1); serve();
    irq1_in = 2'b10; step(2); irq1_in = 2'b00; step(3);
    n_checks++;
    if ({n1_pending[1], pending[1]} !== 2'b10) begin
      n_errors++; $display("FAIL node1_take: n1_pend1=%b n0_pend1=%b, want 1 0", n1_pending[1], pending[1]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      n_checks++;
      if ({irq_req, pending} !== {(m_state == 1), m_pend}) begin
        n_errors++; $display("FAIL rand_irq c=%0d: req=%b pend=%b, want %b %b", c, irq_req, pending, (m_state == 1), m_pend);
      end
      if (m_state == 1) begin
        n_checks++;
        if (irq_vec !== m_vec) begin
          n_errors++; $display("FAIL rand_vec c=%0d: vec=%0d, want %0d", c, irq_vec, m_vec);
        end
      end
      n_checks++;
      if ({cmd_ready, out_op} !== {(m_left == 0), m_op}) begin
        n_errors++; $display("FAIL rand_enc c=%0d: ready=%b op=%h, want %b %h", c, cmd_ready, out_op, (m_left == 0), m_op);
      end
      if ($urandom_range(0, 5) == 0) irq0_in = ~irq0_in;
      if ($urandom_range(0, 5) == 0) irq1_in[0] = ~irq1_in[0];
      if ($urandom_range(0, 5) == 0) irq1_in[1] = ~irq1_in[1];
      if ($urandom_range(0, 5) == 0) irq2_in = ~irq2_in;
      if ($urandom_range(0, 19) == 0) irq_mask = 3'($urandom_range(0, 7));
      irq_ack   = ($urandom_range(0, 2) == 0);
      irq_eoi   = ($urandom_range(0, 3) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_type  = 2'($urandom_range(0, 3));
      cmd_prio  = 4'($urandom_range(0, 15));
      step(1);
    end
    {irq0_in, irq1_in, irq2_in, irq_ack, irq_eoi, cmd_valid} = '0;
    irq_mask = 3'b000;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_priority_mask();
    test_rearm();
    test_level_hold();
    test_encoder();
    test_back_to_back();
    test_node_id1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
